// File: rtl/neo_c1_mem_arb.sv
// Shared 16-bit memory port arbiter between 68K bus cycles and Z80 byte accesses.
// One access per request assertion, round-robin on ties, bounded by a timeout.
module neo_c1_mem_arb #(
  parameter int TIMEOUT_CYC = 255,
  parameter int TO_W        = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        M68K_REQ,
  input  logic [22:0] M68K_ADDR,
  input  logic        M68K_RW,
  input  logic [1:0]  M68K_BE,
  input  logic [15:0] M68K_DOUT,
  output logic [15:0] M68K_DIN,
  output logic        nM68K_DTACK,
  input  logic        Z80_REQ,
  input  logic [23:0] Z80_ADDR,
  input  logic        Z80_RW,
  input  logic [7:0]  Z80_DOUT,
  output logic [7:0]  Z80_DIN,
  output logic        nZ80_WAIT,
  output logic        MEM_REQ,
  output logic [22:0] MEM_ADDR,
  output logic        MEM_WE,
  output logic [1:0]  MEM_BE,
  output logic [15:0] MEM_WDATA,
  input  logic [15:0] MEM_RDATA,
  input  logic        MEM_ACK,
  output logic        TIMEOUT_ERR
);

  typedef enum logic [1:0] {IDLE, BUSY_68K, BUSY_Z80} state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  state_t          state_reg, state_next;
  logic            m68k_done_reg, m68k_done_next;
  logic            z80_done_reg, z80_done_next;
  logic            last_z80_reg, last_z80_next;
  logic [TO_W-1:0] to_cnt_reg, to_cnt_next;
  logic [22:0]     addr_reg, addr_next;
  logic            we_reg, we_next;
  logic [1:0]      be_reg, be_next;
  logic [15:0]     wdata_reg, wdata_next;
  logic [15:0]     m68k_din_reg, m68k_din_next;
  logic [7:0]      z80_din_reg, z80_din_next;
  logic            timeout_err_reg, timeout_err_next;

  logic        elig_68k, elig_z80, grant_68k, grant_z80;
  logic        busy, time_up, finish;
  logic [15:0] rd_word;

  assign elig_68k  = M68K_REQ & ~m68k_done_reg;
  assign elig_z80  = Z80_REQ & ~z80_done_reg;
  // On a tie the Z80 only wins if the 68K was served last.
  assign grant_z80 = elig_z80 & (~elig_68k | ~last_z80_reg);
  assign grant_68k = elig_68k & ~grant_z80;

  assign busy    = (state_reg != IDLE);
  assign time_up = busy & ~MEM_ACK & (to_cnt_reg == TO_LAST);
  assign finish  = busy & (MEM_ACK | time_up);
  assign rd_word = MEM_ACK ? MEM_RDATA : 16'hFFFF;

  always_comb begin
    state_next       = state_reg;
    last_z80_next    = last_z80_reg;
    to_cnt_next      = to_cnt_reg;
    addr_next        = addr_reg;
    we_next          = we_reg;
    be_next          = be_reg;
    wdata_next       = wdata_reg;
    m68k_din_next    = m68k_din_reg;
    z80_din_next     = z80_din_reg;
    timeout_err_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (grant_68k) begin
          state_next    = BUSY_68K;
          last_z80_next = 1'b0;
          to_cnt_next   = '0;
          addr_next     = M68K_ADDR;
          we_next       = ~M68K_RW;
          be_next       = M68K_BE;
          wdata_next    = M68K_DOUT;
        end else if (grant_z80) begin
          state_next    = BUSY_Z80;
          last_z80_next = 1'b1;
          to_cnt_next   = '0;
          addr_next     = Z80_ADDR[23:1];
          we_next       = ~Z80_RW;
          be_next       = Z80_ADDR[0] ? 2'b01 : 2'b10;
          wdata_next    = {Z80_DOUT, Z80_DOUT};
        end
      end
      BUSY_68K, BUSY_Z80: begin
        if (finish) begin
          state_next       = IDLE;
          timeout_err_next = time_up;
          if (!we_reg) begin
            if (state_reg == BUSY_68K)
              m68k_din_next = rd_word;
            else
              z80_din_next = be_reg[1] ? rd_word[15:8] : rd_word[7:0];
          end
        end else begin
          to_cnt_next = to_cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    // A requester that drops REQ mid-access never sees its done flag set.
    m68k_done_next = M68K_REQ & (m68k_done_reg | ((state_reg == BUSY_68K) & finish));
    z80_done_next  = Z80_REQ  & (z80_done_reg  | ((state_reg == BUSY_Z80) & finish));
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg       <= IDLE;
      m68k_done_reg   <= 1'b0;
      z80_done_reg    <= 1'b0;
      last_z80_reg    <= 1'b1;
      to_cnt_reg      <= '0;
      addr_reg        <= '0;
      we_reg          <= 1'b0;
      be_reg          <= 2'b00;
      wdata_reg       <= '0;
      m68k_din_reg    <= '0;
      z80_din_reg     <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      m68k_done_reg   <= m68k_done_next;
      z80_done_reg    <= z80_done_next;
      last_z80_reg    <= last_z80_next;
      to_cnt_reg      <= to_cnt_next;
      addr_reg        <= addr_next;
      we_reg          <= we_next;
      be_reg          <= be_next;
      wdata_reg       <= wdata_next;
      m68k_din_reg    <= m68k_din_next;
      z80_din_reg     <= z80_din_next;
      timeout_err_reg <= timeout_err_next;
    end
  end

  assign MEM_REQ     = busy;
  assign MEM_ADDR    = addr_reg;
  assign MEM_WE      = we_reg;
  assign MEM_BE      = be_reg;
  assign MEM_WDATA   = wdata_reg;
  assign M68K_DIN    = m68k_din_reg;
  assign Z80_DIN     = z80_din_reg;
  assign TIMEOUT_ERR = timeout_err_reg;
  assign nM68K_DTACK = ~m68k_done_reg;
  assign nZ80_WAIT   = ~(Z80_REQ & ~z80_done_reg);

endmodule

// File: tb/tb_neo_c1_mem_arb.sv
// Directed bench for neo_c1_mem_arb: handshake timing, byte lanes, arbitration,
// timeout, reset mid-access and one-access-per-request behaviour.
module tb_neo_c1_mem_arb;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        M68K_REQ;
  logic [22:0] M68K_ADDR;
  logic        M68K_RW;
  logic [1:0]  M68K_BE;
  logic [15:0] M68K_DOUT;
  logic [15:0] M68K_DIN;
  logic        nM68K_DTACK;
  logic        Z80_REQ;
  logic [23:0] Z80_ADDR;
  logic        Z80_RW;
  logic [7:0]  Z80_DOUT;
  logic [7:0]  Z80_DIN;
  logic        nZ80_WAIT;
  logic        MEM_REQ;
  logic [22:0] MEM_ADDR;
  logic        MEM_WE;
  logic [1:0]  MEM_BE;
  logic [15:0] MEM_WDATA;
  logic [15:0] MEM_RDATA;
  logic        MEM_ACK;
  logic        TIMEOUT_ERR;

  int checks = 0;
  int errors = 0;

  neo_c1_mem_arb #(.TIMEOUT_CYC(255), .TO_W(8)) dut (
    .CLK(CLK), .RESET(RESET),
    .M68K_REQ(M68K_REQ), .M68K_ADDR(M68K_ADDR), .M68K_RW(M68K_RW), .M68K_BE(M68K_BE),
    .M68K_DOUT(M68K_DOUT), .M68K_DIN(M68K_DIN), .nM68K_DTACK(nM68K_DTACK),
    .Z80_REQ(Z80_REQ), .Z80_ADDR(Z80_ADDR), .Z80_RW(Z80_RW), .Z80_DOUT(Z80_DOUT),
    .Z80_DIN(Z80_DIN), .nZ80_WAIT(nZ80_WAIT),
    .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR), .MEM_WE(MEM_WE), .MEM_BE(MEM_BE),
    .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA), .MEM_ACK(MEM_ACK),
    .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  always #5 CLK = ~CLK;

  // Request-edge monitor: counts accesses, records granted addresses and idle gaps.
  int           rises = 0;
  int           low_cnt = 0;
  int           min_gap = 1000;
  logic         req_prev = 1'b0;
  logic [22:0]  grant_q[$];

  always @(negedge CLK) begin
    if (MEM_REQ && !req_prev) begin
      rises++;
      grant_q.push_back(MEM_ADDR);
      if (low_cnt < min_gap) min_gap = low_cnt;
      low_cnt = 0;
    end else if (!MEM_REQ) begin
      low_cnt++;
    end
    req_prev = MEM_REQ;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int   base;
    logic served;

    RESET = 1'b1;
    M68K_REQ = 0; M68K_ADDR = '0; M68K_RW = 1; M68K_BE = 2'b11; M68K_DOUT = '0;
    Z80_REQ = 0; Z80_ADDR = '0; Z80_RW = 1; Z80_DOUT = '0;
    MEM_RDATA = '0; MEM_ACK = 0;
    step(2);
    check("rst_mem_req", MEM_REQ, 0);
    check("rst_dtack", nM68K_DTACK, 1);
    check("rst_wait", nZ80_WAIT, 1);
    check("rst_m68k_din", M68K_DIN, 0);
    check("rst_z80_din", Z80_DIN, 0);
    check("rst_timeout", TIMEOUT_ERR, 0);
    check("rst_be", MEM_BE, 0);
    RESET = 1'b0;
    step(1);
    $display("reset done");

    // 68K read, ack three cycles after MEM_REQ rises
    base = rises;
    M68K_REQ = 1; M68K_ADDR = 23'h000100; M68K_RW = 1; M68K_BE = 2'b11;
    step(1);
    check("t1_req", MEM_REQ, 1);
    check("t1_addr", MEM_ADDR, 23'h000100);
    check("t1_we", MEM_WE, 0);
    check("t1_be", MEM_BE, 2'b11);
    step(2);
    check("t1_req_hold", MEM_REQ, 1);
    check("t1_dtack_wait", nM68K_DTACK, 1);
    step(1);
    MEM_ACK = 1; MEM_RDATA = 16'hBEEF;
    step(1);
    MEM_ACK = 0;
    check("t1_req_drop", MEM_REQ, 0);
    check("t1_din", M68K_DIN, 16'hBEEF);
    check("t1_dtack_low", nM68K_DTACK, 0);
    step(2);
    check("t1_dtack_held", nM68K_DTACK, 0);
    M68K_REQ = 0;
    #1;
    check("t1_dtack_reg", nM68K_DTACK, 0);
    step(1);
    check("t1_dtack_high", nM68K_DTACK, 1);
    check("t1_one_req", rises - base, 1);
    $display("68K read addr=000100 data=%h", M68K_DIN);

    // Z80 write to odd byte -> lower lane
    Z80_REQ = 1; Z80_ADDR = 24'h000201; Z80_RW = 0; Z80_DOUT = 8'h5A;
    #1;
    check("t2_wait_low", nZ80_WAIT, 0);
    step(1);
    check("t2_req", MEM_REQ, 1);
    check("t2_addr", MEM_ADDR, 23'h000100);
    check("t2_be", MEM_BE, 2'b01);
    check("t2_wdata", MEM_WDATA, 16'h5A5A);
    check("t2_we", MEM_WE, 1);
    check("t2_wait_busy", nZ80_WAIT, 0);
    MEM_ACK = 1;
    step(1);
    MEM_ACK = 0;
    check("t2_wait_high", nZ80_WAIT, 1);
    check("t2_req_drop", MEM_REQ, 0);
    Z80_REQ = 0;
    step(1);
    $display("Z80 write addr=000201 data=5a");

    // Simultaneous requests, three rounds
    grant_q.delete();
    min_gap = 1000;
    M68K_ADDR = 23'h000AAA; M68K_RW = 1; Z80_ADDR = 24'h002000; Z80_RW = 1;
    MEM_RDATA = 16'h1234;
    for (int r = 0; r < 3; r++) begin
      M68K_REQ = 1; Z80_REQ = 1;
      served = 0;
      for (int c = 0; c < 40 && !served; c++) begin
        step(1);
        MEM_ACK = (MEM_REQ && !MEM_ACK) ? 1'b1 : 1'b0;
        served = (nM68K_DTACK == 1'b0) && (nZ80_WAIT == 1'b1) && !MEM_REQ;
      end
      MEM_ACK = 0;
      check("t3_round_served", served, 1);
      if (r == 0) begin
        check("t3_m68k_din", M68K_DIN, 16'h1234);
        check("t3_z80_din", Z80_DIN, 8'h12);
      end
      M68K_REQ = 0; Z80_REQ = 0;
      step(1);
      $display("tie round %0d served", r);
    end
    check("t3_grants", grant_q.size(), 6);
    for (int i = 0; i < 6 && i < grant_q.size(); i++)
      check("t3_order", grant_q[i], (i % 2 == 0) ? 23'h000AAA : 23'h001000);
    check("t3_gap", (min_gap >= 1), 1);

    // Timeout on a 68K read
    base = rises;
    M68K_REQ = 1; M68K_ADDR = 23'h000123; M68K_RW = 1;
    step(1);
    check("t4_req", MEM_REQ, 1);
    step(254);
    check("t4_req_last", MEM_REQ, 1);
    check("t4_no_err_yet", TIMEOUT_ERR, 0);
    step(1);
    check("t4_req_drop", MEM_REQ, 0);
    check("t4_err", TIMEOUT_ERR, 1);
    check("t4_din", M68K_DIN, 16'hFFFF);
    check("t4_dtack", nM68K_DTACK, 0);
    MEM_ACK = 1; MEM_RDATA = 16'h0000;
    step(1);
    MEM_ACK = 0;
    check("t4_err_pulse", TIMEOUT_ERR, 0);
    check("t4_late_ack_din", M68K_DIN, 16'hFFFF);
    check("t4_late_ack_req", MEM_REQ, 0);
    check("t4_one_req", rises - base, 1);
    M68K_REQ = 0;
    step(1);
    $display("68K timeout addr=000123 data=%h", M68K_DIN);

    // Reset during a Z80 access
    Z80_REQ = 1; Z80_ADDR = 24'h000301; Z80_RW = 1;
    step(1);
    check("t5_req", MEM_REQ, 1);
    step(1);
    RESET = 1;
    #1;
    check("t5_rst_req", MEM_REQ, 0);
    check("t5_rst_be", MEM_BE, 0);
    check("t5_rst_addr", MEM_ADDR, 0);
    check("t5_rst_wait", nZ80_WAIT, 0);
    step(1);
    RESET = 0;
    #1;
    check("t5_no_stale", nZ80_WAIT, 0);
    step(1);
    check("t5_reissue", MEM_REQ, 1);
    check("t5_addr", MEM_ADDR, 23'h000180);
    check("t5_be", MEM_BE, 2'b01);
    MEM_ACK = 1; MEM_RDATA = 16'hA55A;
    step(1);
    MEM_ACK = 0;
    check("t5_din", Z80_DIN, 8'h5A);
    check("t5_wait_high", nZ80_WAIT, 1);
    Z80_REQ = 0;
    step(1);
    $display("Z80 read after reset addr=000301 data=%h", Z80_DIN);

    // 68K held after completion, pending Z80 granted at M+1
    M68K_REQ = 1; M68K_ADDR = 23'h000040; M68K_RW = 1;
    step(1);
    check("t6_req", MEM_REQ, 1);
    Z80_REQ = 1; Z80_ADDR = 24'h000100; Z80_RW = 1;
    MEM_ACK = 1; MEM_RDATA = 16'h7777;
    step(1);
    MEM_ACK = 0;
    check("t6_req_drop", MEM_REQ, 0);
    check("t6_dtack", nM68K_DTACK, 0);
    check("t6_wait_pending", nZ80_WAIT, 0);
    check("t6_m68k_din", M68K_DIN, 16'h7777);
    step(1);
    check("t6_z80_granted", MEM_REQ, 1);
    check("t6_z80_addr", MEM_ADDR, 23'h000080);
    check("t6_z80_be", MEM_BE, 2'b10);
    MEM_ACK = 1; MEM_RDATA = 16'hC3D4;
    step(1);
    MEM_ACK = 0;
    check("t6_z80_din", Z80_DIN, 8'hC3);
    check("t6_wait_high", nZ80_WAIT, 1);
    base = rises;
    step(20);
    check("t6_no_second", rises - base, 0);
    check("t6_idle", MEM_REQ, 0);
    check("t6_dtack_held", nM68K_DTACK, 0);
    M68K_REQ = 0; Z80_REQ = 0;
    step(2);
    $display("held request: 68K data=%h Z80 data=%h", M68K_DIN, Z80_DIN);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
